// File: rtl/branch_predict_gshare.sv
// Gshare / bimodal branch direction predictor.
// Predicts in ID from a 2-bit counter pattern history table (PHT) and
// speculatively shifts the prediction into the global history register (GHR).
// Counters are trained at EX resolution using the index piped down with the
// branch. A mispredict rebuilds the GHR from the checkpoint carried with the
// branch. After reset the PHT is cleared by a sweep, one entry per cycle,
// and the predictor reports ready once every entry has been written.
module branch_predict_gshare #(
    parameter int         GHR_WIDTH       = 10,
    parameter int         PHT_INDEX_WIDTH = 10,
    parameter int         PC_LSB          = 2,
    parameter logic [1:0] INIT_STATE      = 2'b10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mode,
    input  logic [31:0]                pcD,
    input  logic                       branchD,
    input  logic                       stallD,
    input  logic                       flushD,
    output logic                       pred_takeD,
    output logic [PHT_INDEX_WIDTH-1:0] pred_indexD,
    output logic [GHR_WIDTH-1:0]       ghr_snapD,
    input  logic                       resolve_validE,
    input  logic [PHT_INDEX_WIDTH-1:0] resolve_indexE,
    input  logic [GHR_WIDTH-1:0]       resolve_ghrE,
    input  logic                       pred_takeE,
    input  logic                       actual_takeE,
    output logic                       preErrorE,
    output logic                       ready,
    output logic [31:0]                stat_branches,
    output logic [31:0]                stat_mispredicts
);

    localparam int                         PHT_ENTRIES = 1 << PHT_INDEX_WIDTH;
    localparam logic [PHT_INDEX_WIDTH-1:0] LAST_INDEX  = '1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                       state_q;
    logic [PHT_INDEX_WIDTH-1:0]   sweep_ptr_q;
    logic                         ready_q;

    logic [1:0]                   pht_mem [0:PHT_ENTRIES-1];

    logic [GHR_WIDTH-1:0]         ghr_q;
    logic [GHR_WIDTH-1:0]         ghr_d;
    logic [31:0]                  stat_branches_q;
    logic [31:0]                  stat_branches_d;
    logic [31:0]                  stat_mispredicts_q;
    logic [31:0]                  stat_mispredicts_d;

    logic [PHT_INDEX_WIDTH-1:0]   pc_idx;
    logic [PHT_INDEX_WIDTH-1:0]   ghr_ext;
    logic [PHT_INDEX_WIDTH-1:0]   pred_idx;
    logic                         pred_take;
    logic                         pre_error;

    logic [GHR_WIDTH:0]           spec_cat;
    logic [GHR_WIDTH:0]           recover_cat;

    logic                         pht_we;
    logic [PHT_INDEX_WIDTH-1:0]   pht_waddr;
    logic [1:0]                   pht_wdata;
    logic [1:0]                   pht_cur;

    logic                         unused_bits;

    // Init sweep FSM: walk every PHT entry once after reset, then run.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            sweep_ptr_q <= '0;
            ready_q     <= 1'b0;
        end else if (state_q == ST_INIT) begin
            sweep_ptr_q <= sweep_ptr_q + PHT_INDEX_WIDTH'(1);
            if (sweep_ptr_q == LAST_INDEX) begin
                state_q <= ST_RUN;
                ready_q <= 1'b1;
            end
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Prediction index: PC bits, optionally folded with the history in the LSBs.
    always_comb begin
        pc_idx                   = pcD[PC_LSB +: PHT_INDEX_WIDTH];
        ghr_ext                  = '0;
        ghr_ext[GHR_WIDTH-1:0]   = ghr_q;
        pred_idx                 = mode ? (pc_idx ^ ghr_ext) : pc_idx;
    end

    assign pred_take = ready_q & branchD & pht_mem[pred_idx][1];
    assign pre_error = resolve_validE & (pred_takeE ^ actual_takeE);

    // Next history: a mispredict rebuilds from the checkpoint and wins over the
    // wrong-path shift of the branch currently in ID.
    always_comb begin
        spec_cat    = {ghr_q, pred_take};
        recover_cat = {resolve_ghrE, actual_takeE};
        ghr_d       = ghr_q;
        if (ready_q) begin
            if (pre_error) begin
                ghr_d = recover_cat[GHR_WIDTH-1:0];
            end else if (branchD & ~stallD & ~flushD) begin
                ghr_d = spec_cat[GHR_WIDTH-1:0];
            end
        end
    end

    // History register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    // Single PHT write port shared by the sweep and the resolution update.
    always_comb begin
        pht_we    = 1'b0;
        pht_waddr = sweep_ptr_q;
        pht_wdata = INIT_STATE;
        pht_cur   = pht_mem[resolve_indexE];
        if (!rst) begin
            if (!ready_q) begin
                pht_we = 1'b1;
            end else if (resolve_validE) begin
                pht_we    = 1'b1;
                pht_waddr = resolve_indexE;
                if (actual_takeE) begin
                    pht_wdata = (pht_cur == 2'b11) ? pht_cur : pht_cur + 2'd1;
                end else begin
                    pht_wdata = (pht_cur == 2'b00) ? pht_cur : pht_cur - 2'd1;
                end
            end
        end
    end

    // PHT storage; reads are combinational and see the pre-write value.
    always_ff @(posedge clk) begin
        if (pht_we) begin
            pht_mem[pht_waddr] <= pht_wdata;
        end
    end

    // Saturating statistics, only counted once the predictor is live.
    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (ready_q & resolve_validE & ~(&stat_branches_q)) begin
            stat_branches_d = stat_branches_q + 32'd1;
        end
        if (ready_q & pre_error & ~(&stat_mispredicts_q)) begin
            stat_mispredicts_d = stat_mispredicts_q + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign unused_bits      = ^{pcD, spec_cat[GHR_WIDTH], recover_cat[GHR_WIDTH]};

    assign pred_takeD       = pred_take;
    assign pred_indexD      = pred_idx;
    assign ghr_snapD        = ghr_q;
    assign preErrorE        = pre_error;
    assign ready            = ready_q;
    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predict_gshare.sv
// Testbench for branch_predict_gshare at default parameters.
// A behavioural model (integer counters, integer history) tracks the expected
// outputs and is compared every negedge; directed literal checks pin it.
module tb_branch_predict_gshare;

    localparam int ENTRIES = 1024;
    localparam int GMASK   = 1023;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [31:0] pcD;
    logic        branchD;
    logic        stallD;
    logic        flushD;
    logic        pred_takeD;
    logic [9:0]  pred_indexD;
    logic [9:0]  ghr_snapD;
    logic        resolve_validE;
    logic [9:0]  resolve_indexE;
    logic [9:0]  resolve_ghrE;
    logic        pred_takeE;
    logic        actual_takeE;
    logic        preErrorE;
    logic        ready;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int    checks   = 0;
    int    errors   = 0;
    bit    check_en = 1'b0;

    int     m_pht [ENTRIES];
    int     m_ghr      = 0;
    bit     m_ready    = 1'b0;
    int     m_sweep    = 0;
    longint m_branches = 0;
    longint m_mis      = 0;

    int zero_cycles;

    always #5 clk = ~clk;

    branch_predict_gshare dut (
        .clk              (clk),
        .rst              (rst),
        .mode             (mode),
        .pcD              (pcD),
        .branchD          (branchD),
        .stallD           (stallD),
        .flushD           (flushD),
        .pred_takeD       (pred_takeD),
        .pred_indexD      (pred_indexD),
        .ghr_snapD        (ghr_snapD),
        .resolve_validE   (resolve_validE),
        .resolve_indexE   (resolve_indexE),
        .resolve_ghrE     (resolve_ghrE),
        .pred_takeE       (pred_takeE),
        .actual_takeE     (actual_takeE),
        .preErrorE        (preErrorE),
        .ready            (ready),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_index();
        int pc_idx;
        pc_idx = int'((pcD >> 2) & 32'h3FF);
        return mode ? (pc_idx ^ m_ghr) : pc_idx;
    endfunction

    function automatic bit model_pred();
        return m_ready && branchD && (m_pht[model_index()] >= 2);
    endfunction

    function automatic bit model_perr();
        return resolve_validE && (pred_takeE != actual_takeE);
    endfunction

    // Model state advance on each rising edge from the inputs held across it.
    always @(posedge clk) begin : model_blk
        bit p;
        bit e;
        int idx;
        if (rst) begin
            m_ready    = 1'b0;
            m_sweep    = 0;
            m_ghr      = 0;
            m_branches = 0;
            m_mis      = 0;
        end else if (!m_ready) begin
            m_sweep++;
            if (m_sweep == ENTRIES) begin
                m_ready = 1'b1;
                foreach (m_pht[i]) m_pht[i] = 2;
            end
        end else begin
            p = model_pred();
            e = model_perr();
            if (e) begin
                m_ghr = ((int'(resolve_ghrE) << 1) | int'(actual_takeE)) & GMASK;
            end else if (branchD && !stallD && !flushD) begin
                m_ghr = ((m_ghr << 1) | int'(p)) & GMASK;
            end
            if (resolve_validE) begin
                idx = int'(resolve_indexE);
                if (actual_takeE) begin
                    if (m_pht[idx] < 3) m_pht[idx]++;
                end else begin
                    if (m_pht[idx] > 0) m_pht[idx]--;
                end
                if (m_branches < 64'hFFFFFFFF) m_branches++;
            end
            if (e && m_mis < 64'hFFFFFFFF) m_mis++;
        end
    end

    // Continuous compare of every output against the model.
    always @(negedge clk) begin
        if (check_en) begin
            check_output("ready", ready, m_ready);
            check_output("pred_takeD", pred_takeD, model_pred());
            check_output("pred_indexD", pred_indexD, model_index());
            check_output("ghr_snapD", ghr_snapD, m_ghr);
            check_output("preErrorE", preErrorE, model_perr());
            check_output("stat_branches", stat_branches, m_branches);
            check_output("stat_mispredicts", stat_mispredicts, m_mis);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input bit br, input logic [31:0] pc, input bit md, input bit st, input bit fl);
        branchD = br;
        pcD     = pc;
        mode    = md;
        stallD  = st;
        flushD  = fl;
    endtask

    task automatic set_resolve(input bit v, input logic [9:0] idx, input logic [9:0] ghr, input bit pt, input bit at);
        resolve_validE = v;
        resolve_indexE = idx;
        resolve_ghrE   = ghr;
        pred_takeE     = pt;
        actual_takeE   = at;
    endtask

    task automatic wait_ready(input int inject_at, output int n);
        n = 0;
        for (int k = 0; k < 1100; k++) begin
            @(negedge clk);
            if (ready === 1'b1) break;
            n++;
            if (n == inject_at) begin
                #1;
                set_resolve(1'b1, 10'h001, 10'h3FF, 1'b1, 1'b0);
            end else if (n == inject_at + 1) begin
                #1;
                set_resolve(1'b0, 10'h000, 10'h000, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic resolve_cycle(input logic [9:0] idx, input bit taken, input bit read_same);
        next_cycle();
        apply_stimulus(read_same, 32'h100, 1'b0, 1'b1, 1'b0);
        set_resolve(1'b1, idx, 10'h000, taken, taken);
        @(negedge clk);
    endtask

    task automatic observe_cycle(input logic [31:0] pc, input bit md);
        next_cycle();
        set_resolve(1'b0, 10'h000, 10'h000, 1'b0, 1'b0);
        apply_stimulus(1'b1, pc, md, 1'b1, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        set_resolve(1'b0, 10'h000, 10'h000, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        check_en = 1'b1;

        // Sweep after reset: ready low for exactly 1024 cycles.
        wait_ready(0, zero_cycles);
        check_output("reset_ready_latency", zero_cycles, 1024);

        // Every entry starts weakly taken.
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            apply_stimulus(1'b1, $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            @(negedge clk);
            check_output("sweep_pred_taken", pred_takeD, 1);
        end

        // Saturation at bimodal index 0x040.
        resolve_cycle(10'h040, 1'b0, 1'b0);
        resolve_cycle(10'h040, 1'b0, 1'b0);
        observe_cycle(32'h100, 1'b0);
        check_output("sat_index", pred_indexD, 10'h040);
        check_output("sat_nt_pred", pred_takeD, 0);
        for (int i = 0; i < 4; i++) resolve_cycle(10'h040, 1'b1, 1'b0);
        observe_cycle(32'h100, 1'b0);
        check_output("sat_t_pred", pred_takeD, 1);
        check_output("sat_branches6", stat_branches, 6);
        resolve_cycle(10'h040, 1'b0, 1'b1);
        check_output("nobypass_first", pred_takeD, 1);
        resolve_cycle(10'h040, 1'b0, 1'b1);
        check_output("nobypass_second", pred_takeD, 1);
        observe_cycle(32'h100, 1'b0);
        check_output("sat_after_two_nt", pred_takeD, 0);

        // Speculative history shift in gshare mode.
        next_cycle();
        set_resolve(1'b0, 10'h000, 10'h000, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check_output("spec_index0", pred_indexD, 10'h000);
        check_output("spec_snap0", ghr_snapD, 10'h000);
        check_output("spec_pred0", pred_takeD, 1);
        next_cycle();
        apply_stimulus(1'b1, 32'h4, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check_output("spec_snap1", ghr_snapD, 10'h001);
        check_output("spec_index1", pred_indexD, 10'h000);

        // Mispredict recovery beats the same-cycle shift.
        next_cycle();
        apply_stimulus(1'b1, 32'h8, 1'b1, 1'b0, 1'b0);
        set_resolve(1'b1, 10'h010, 10'h155, 1'b1, 1'b0);
        @(negedge clk);
        check_output("recover_preError", preErrorE, 1);
        next_cycle();
        set_resolve(1'b0, 10'h000, 10'h000, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check_output("recover_ghr", ghr_snapD, 10'h2AA);
        check_output("recover_mispredicts", stat_mispredicts, 1);
        check_output("recover_branches", stat_branches, 9);

        // Stall holds history and prediction.
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            @(negedge clk);
            check_output("stall_ghr", ghr_snapD, 10'h2AA);
            check_output("stall_pred", pred_takeD, 1);
        end

        // Flush suppresses the shift while resolution still counts.
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            if (k == 0) begin
                apply_stimulus(1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
                set_resolve(1'b1, 10'h020, 10'h000, 1'b1, 1'b1);
            end else begin
                set_resolve(1'b0, 10'h000, 10'h000, 1'b0, 1'b0);
            end
            @(negedge clk);
            check_output("flush_ghr", ghr_snapD, 10'h2AA);
        end
        check_output("flush_branches", stat_branches, 10);

        // Reset in the middle of the sweep restarts it.
        next_cycle();
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        repeat (500) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        wait_ready(5, zero_cycles);
        check_output("midinit_ready_latency", zero_cycles, 1024);
        check_output("midinit_branches", stat_branches, 0);
        check_output("midinit_mispredicts", stat_mispredicts, 0);
        check_output("midinit_ghr", ghr_snapD, 0);
        next_cycle();
        set_resolve(1'b0, 10'h000, 10'h000, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h4, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_output("midinit_pht_kept", pred_takeD, 1);

        next_cycle();
        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: simulation did not complete, time %0t", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_predict_gshare.md
# branch_predict_gshare

Parametrised gshare/bimodal direction predictor for the 5-stage pipeline (IF | ID | EX | MEM | WB). It predicts in ID and speculatively updates the global history register (GHR) with the prediction. It updates the pattern history table (PHT) at EX resolution using the index carried down the pipe, and restores the GHR from a checkpoint on mispredict. An init sweep FSM clears the PHT after reset instead of a single-cycle array reset, and saturating statistics counters are provided.

## Interface
Parameters:
- GHR_WIDTH, 10, global history bits; legal range 1..PHT_INDEX_WIDTH.
- PHT_INDEX_WIDTH, 10, log2 of PHT entries.
- PC_LSB, 2, lowest PC bit used for indexing.
- INIT_STATE, 2'b10, PHT counter value written by the init sweep (weakly taken).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- mode  in  1  0 = bimodal (PC-only index), 1 = gshare (PC XOR GHR).
- pcD  in  32  PC of the instruction in ID.
- branchD  in  1  instruction in ID is a conditional branch.
- stallD  in  1  ID stalled.
- flushD  in  1  ID being flushed.
- pred_takeD  out  1  predicted taken.
- pred_indexD  out  PHT_INDEX_WIDTH  PHT index used; the datapath pipes it to EX.
- ghr_snapD  out  GHR_WIDTH  GHR before the speculative shift; the datapath pipes it to EX.
- resolve_validE  in  1  a branch resolves in EX this cycle.
- resolve_indexE  in  PHT_INDEX_WIDTH  piped pred_indexD.
- resolve_ghrE  in  GHR_WIDTH  piped ghr_snapD.
- pred_takeE  in  1  piped pred_takeD.
- actual_takeE  in  1  resolved direction.
- preErrorE  out  1  resolve_validE & (pred_takeE != actual_takeE); combinational.
- ready  out  1  init sweep complete.
- stat_branches  out  32  resolved-branch count.
- stat_mispredicts  out  32  mispredict count.

## Operation
- FSM with 2 states: INIT and RUN.
  - rst forces INIT and sets sweep pointer = 0.
  - INIT writes INIT_STATE to PHT[pointer] each cycle and increments the pointer. After writing the last entry (all ones), it moves to RUN.
  - In RUN, ready = 1.
  - rst during INIT or RUN restarts the sweep at 0.
- Index calculation:
  - pc_idx = pcD[PC_LSB +: PHT_INDEX_WIDTH].
  - gshare: idx = pc_idx ^ {zeros, GHR} (GHR zero-extended into the LSBs).
  - bimodal: idx = pc_idx.
  - pred_indexD = idx and ghr_snapD = GHR, combinational, always driven.
- pred_takeD = ready & branchD & PHT[idx][1]. The PHT read is combinational.
- Speculative shift: when ready & branchD & ~stallD & ~flushD, then GHR <= {GHR[GHR_WIDTH-2:0], pred_takeD}. For GHR_WIDTH = 1, GHR <= pred_takeD.
- Recovery: when ready & preErrorE, then GHR <= {resolve_ghrE[GHR_WIDTH-2:0], actual_takeE}.
  - Recovery has priority over a same-cycle speculative shift, because the ID instruction is on the wrong path.
- PHT update: when ready & resolve_validE, PHT[resolve_indexE] becomes the 2-bit saturating counter moved toward actual_takeE.
  - 11 stays 11 on taken; 00 stays 00 on not-taken.
  - The update happens whether or not the prediction was correct.
- No read bypass: an ID read of the entry being written that cycle returns the old value.
- Statistics:
  - stat_branches increments on ready & resolve_validE.
  - stat_mispredicts increments on ready & preErrorE.
  - Both saturate at 32'hFFFFFFFF.
- While ~ready: no GHR change, no PHT update from resolution, no stat change, pred_takeD = 0.

## Timing
- Reset values: ready = 0, GHR = 0, stats = 0, pred_takeD = 0.
- ready rises exactly 2^PHT_INDEX_WIDTH cycles after the first clock edge with rst low (1024 cycles at defaults).
- The prediction is available in the same cycle that branchD/pcD are presented.
- The GHR, PHT and stats take effect on the next posedge. Latency is 1 cycle from the resolving edge to a new prediction.
- stallD holds the GHR, so pred_takeD stays stable while pcD is stable.
- flushD suppresses the shift only; resolution still proceeds.
- The PHT is 2^PHT_INDEX_WIDTH × 2 bits with one write port. INIT writes and resolve writes never coexist, because resolve is gated by ready.

## Test plan
- Reset sweep: pulse rst for 1 cycle -> ready = 0 for exactly 1024 cycles, then 1. Random pcD with branchD = 1 -> pred_takeD = 1 for every entry.
- Saturation (mode = 0, pcD = 0x100, index 0x040):
  - 2 not-taken resolves at index 0x040 -> pred_takeD = 0.
  - 3 taken resolves -> counter = 11.
  - A further taken resolve -> counter remains 11; stat_branches = 6.
- Speculation (mode = 1, GHR = 0):
  - Branch at pcD = 0x0 -> pred_indexD = 0x000, ghr_snapD = 0x000, prediction taken; next cycle GHR = 0x001.
  - Branch at pcD = 0x4 -> pred_indexD = 0x001 ^ 0x001 = 0x000.
- Recovery priority: resolve_ghrE = 0x155, pred_takeE = 1, actual_takeE = 0, with an unstalled branchD in the same cycle -> preErrorE = 1, GHR next = 0x2AA, stat_mispredicts += 1.
- Stall/flush: branchD with stallD = 1 for 3 cycles -> GHR unchanged and pred_takeD constant. branchD with flushD = 1 -> GHR unchanged.
- Reset mid-init: rst at sweep cycle 500 -> ready rises 1024 cycles after rst deasserts. A resolve_validE during INIT -> PHT and stats unchanged.
